// File: rtl/cp0_ctrl_v2_pkg.sv
// Shared constants for the CP0 controller: register addresses, exception
// codes, reset values and small address helpers.
package cp0_ctrl_v2_pkg;

  // Register addresses (CP0 register numbers)
  localparam logic [4:0] ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] ADDR_COUNT    = 5'd9;
  localparam logic [4:0] ADDR_COMPARE0 = 5'd11;
  localparam logic [4:0] ADDR_STATUS   = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;
  localparam logic [4:0] ADDR_PRID     = 5'd15;
  localparam logic [4:0] ADDR_CONFIG   = 5'd16;
  // Extra compare channels k>=1 live at ADDR_COMPARE_BASE + k
  localparam int         ADDR_COMPARE_BASE = 24;

  // Reset / constant register contents
  localparam logic [31:0] STATUS_RESET = 32'h1000_0000;
  localparam logic [31:0] CONFIG_VALUE = 32'h0000_8000;

  // ExcCode values
  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_MOD  = 5'd1,
    EXC_TLBL = 5'd2,
    EXC_TLBS = 5'd3,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_IBE  = 5'd6,
    EXC_DBE  = 5'd7,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_CPU  = 5'd11,
    EXC_OV   = 5'd12,
    EXC_TR   = 5'd13
  } exc_code_e;

  // Address-error exceptions are the only ones that capture BadVAddr
  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

  // Channel 0 sits at the classic Compare address, the rest above 24
  function automatic logic [4:0] compare_addr(input int k);
    return (k == 0) ? ADDR_COMPARE0 : 5'(ADDR_COMPARE_BASE + k);
  endfunction

endpackage

// File: rtl/cp0_ctrl_v2_if.sv
// Bundle of the CP0 register bus, exception commit strobes and live outputs.
// Strobe semantics: we_i, exc_valid_i and eret_i are single-cycle commit
// strobes sampled on every rising clk edge; there is no back-pressure, the
// CP0 always accepts them. rdata_o is combinational from raddr_i.
interface cp0_ctrl_v2_if #(
  parameter int NUM_TIMERS = 2,
  parameter int NUM_HW_INT = 5
) ();
  import cp0_ctrl_v2_pkg::*;

  logic                  we_i;
  logic [4:0]            waddr_i;
  logic [4:0]            raddr_i;
  logic [31:0]           wdata_i;
  logic [31:0]           rdata_o;
  logic [NUM_HW_INT-1:0] int_i;
  logic                  exc_valid_i;
  logic [4:0]            exc_code_i;
  logic [31:0]           exc_pc_i;
  logic                  exc_bd_i;
  logic [31:0]           exc_badvaddr_i;
  logic                  eret_i;
  logic [31:0]           status_o;
  logic [31:0]           cause_o;
  logic [31:0]           epc_o;
  logic                  int_req_o;
  logic [NUM_TIMERS-1:0] timer_int_o;

  modport master (
    output we_i, waddr_i, raddr_i, wdata_i, int_i, exc_valid_i, exc_code_i,
           exc_pc_i, exc_bd_i, exc_badvaddr_i, eret_i,
    input  rdata_o, status_o, cause_o, epc_o, int_req_o, timer_int_o
  );

  modport slave (
    input  we_i, waddr_i, raddr_i, wdata_i, int_i, exc_valid_i, exc_code_i,
           exc_pc_i, exc_bd_i, exc_badvaddr_i, eret_i,
    output rdata_o, status_o, cause_o, epc_o, int_req_o, timer_int_o
  );

endinterface

// File: rtl/cp0_ctrl_v2_timer_chan.sv
// One compare/timer channel: compare register, match detect against Count
// and a sticky pending flag cleared only by writing the compare register.
module cp0_timer_chan
  import cp0_ctrl_v2_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] count_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] compare_o,
  output logic        pending_o
);

  logic [31:0] compare_q, compare_d;
  logic        pending_q, pending_d;

  // Next state: a write reloads compare and wins over a same-cycle match;
  // compare==0 means the channel is disarmed
  always_comb begin
    compare_d = compare_q;
    pending_d = pending_q;
    if (we_i) begin
      compare_d = wdata_i;
      pending_d = 1'b0;
    end else if ((count_i == compare_q) && (compare_q != 32'd0)) begin
      pending_d = 1'b1;
    end
  end

  // Channel state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      compare_q <= 32'd0;
      pending_q <= 1'b0;
    end else begin
      compare_q <= compare_d;
      pending_q <= pending_d;
    end
  end

  assign compare_o = compare_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/cp0_ctrl_v2.sv
// CP0 controller: Count/Compare timers, Status/Cause/EPC/BadVAddr with
// exception and eret commit handling, and the masked interrupt request.
module cp0_ctrl_v2 #(
  parameter int          NUM_TIMERS = 2,
  parameter int          NUM_HW_INT = 5,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] PRID_VALUE = 32'h004C_0102
) (
  input logic          clk,
  input logic          rst,
  cp0_ctrl_v2_if.slave bus
);
  import cp0_ctrl_v2_pkg::*;

  logic [31:0]           count_q, count_d;
  logic                  presc_q, presc_d;
  logic [31:0]           badvaddr_q, badvaddr_d;
  logic [31:0]           epc_q, epc_d;
  logic [7:0]            im_q, im_d;
  logic                  exl_q, exl_d;
  logic                  ie_q, ie_d;
  logic                  bd_q, bd_d;
  logic                  iv_q, iv_d;
  logic [1:0]            ip_sw_q, ip_sw_d;
  logic [4:0]            exccode_q, exccode_d;
  logic [NUM_HW_INT-1:0] hw_q;

  logic [NUM_TIMERS-1:0] pend;
  logic [31:0]           cmp_val [NUM_TIMERS];
  logic [7:0]            ip;
  logic [31:0]           status_w, cause_w;
  logic                  wr_count, wr_status, wr_cause, wr_epc, tick;

  assign wr_count  = bus.we_i && (bus.waddr_i == ADDR_COUNT);
  assign wr_status = bus.we_i && (bus.waddr_i == ADDR_STATUS);
  assign wr_cause  = bus.we_i && (bus.waddr_i == ADDR_CAUSE);
  assign wr_epc    = bus.we_i && (bus.waddr_i == ADDR_EPC);
  // With a divide of 1 every clock is a tick; otherwise every second one
  assign tick      = (COUNT_DIV == 1) || presc_q;

  for (genvar k = 0; k < NUM_TIMERS; k++) begin : g_timer
    cp0_timer_chan u_chan (
      .clk       (clk),
      .rst       (rst),
      .count_i   (count_q),
      .we_i      (bus.we_i && (bus.waddr_i == compare_addr(k))),
      .wdata_i   (bus.wdata_i),
      .compare_o (cmp_val[k]),
      .pending_o (pend[k])
    );
  end

  assign ip       = {|pend, 5'(hw_q), ip_sw_q};
  assign status_w = {3'b000, 1'b1, 12'h000, im_q, 6'b00_0000, exl_q, ie_q};
  assign cause_w  = {bd_q, 7'd0, iv_q, 7'd0, ip, 1'b0, exccode_q, 2'b00};

  // Next-state: Count prescaler, software writes, then exception/eret
  // commits layered on top so they win over writes to the same field
  always_comb begin
    count_d    = count_q;
    presc_d    = presc_q;
    badvaddr_d = badvaddr_q;
    epc_d      = epc_q;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    iv_d       = iv_q;
    ip_sw_d    = ip_sw_q;
    exccode_d  = exccode_q;

    if (wr_count) begin
      count_d = bus.wdata_i;
      presc_d = 1'b0;
    end else begin
      presc_d = ~tick;
      if (tick) count_d = count_q + 32'd1;
    end

    if (wr_status) begin
      im_d  = bus.wdata_i[15:8];
      exl_d = bus.wdata_i[1];
      ie_d  = bus.wdata_i[0];
    end
    if (wr_cause) begin
      iv_d    = bus.wdata_i[23];
      ip_sw_d = bus.wdata_i[9:8];
    end
    if (wr_epc) epc_d = bus.wdata_i;

    if (bus.exc_valid_i) begin
      // A nested exception (EXL already set) keeps the original EPC/BD
      epc_d = epc_q;
      bd_d  = bd_q;
      if (!exl_q) begin
        epc_d = bus.exc_bd_i ? (bus.exc_pc_i - 32'd4) : bus.exc_pc_i;
        bd_d  = bus.exc_bd_i;
      end
      exl_d     = 1'b1;
      exccode_d = bus.exc_code_i;
      if (is_addr_exc(bus.exc_code_i)) badvaddr_d = bus.exc_badvaddr_i;
    end else if (bus.eret_i) begin
      exl_d = 1'b0;
    end
  end

  // Architectural register file
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= 32'd0;
      presc_q    <= 1'b0;
      badvaddr_q <= 32'd0;
      epc_q      <= 32'd0;
      im_q       <= STATUS_RESET[15:8];
      exl_q      <= STATUS_RESET[1];
      ie_q       <= STATUS_RESET[0];
      bd_q       <= 1'b0;
      iv_q       <= 1'b0;
      ip_sw_q    <= 2'b00;
      exccode_q  <= 5'd0;
      hw_q       <= '0;
    end else begin
      count_q    <= count_d;
      presc_q    <= presc_d;
      badvaddr_q <= badvaddr_d;
      epc_q      <= epc_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      iv_q       <= iv_d;
      ip_sw_q    <= ip_sw_d;
      exccode_q  <= exccode_d;
      hw_q       <= bus.int_i;
    end
  end

  // Read mux from current register values (no write bypass)
  always_comb begin
    bus.rdata_o = 32'd0;
    case (bus.raddr_i)
      ADDR_BADVADDR: bus.rdata_o = badvaddr_q;
      ADDR_COUNT:    bus.rdata_o = count_q;
      ADDR_STATUS:   bus.rdata_o = status_w;
      ADDR_CAUSE:    bus.rdata_o = cause_w;
      ADDR_EPC:      bus.rdata_o = epc_q;
      ADDR_PRID:     bus.rdata_o = PRID_VALUE;
      ADDR_CONFIG:   bus.rdata_o = CONFIG_VALUE;
      default:       bus.rdata_o = 32'd0;
    endcase
    for (int k = 0; k < NUM_TIMERS; k++) begin
      if (bus.raddr_i == compare_addr(k)) bus.rdata_o = cmp_val[k];
    end
  end

  assign bus.status_o    = status_w;
  assign bus.cause_o     = cause_w;
  assign bus.epc_o       = epc_q;
  assign bus.timer_int_o = pend;
  assign bus.int_req_o   = ie_q & ~exl_q & (|(ip & im_q));

endmodule

// File: doc/cp0_ctrl_v2.md
CP0_CTRL_V2 -- requirements
Module: cp0_ctrl_v2

Interface
REQ-001 SHALL have parameter NUM_TIMERS, default 2, number of compare/timer channels (1..4).
REQ-002 SHALL have parameter NUM_HW_INT, default 5, number of external interrupt lines (1..5).
REQ-003 SHALL have parameter COUNT_DIV, default 2, clocks per Count increment (1 or 2).
REQ-004 SHALL have parameter PRID_VALUE, default 32'h004C0102, read-only PRId content.
REQ-005 SHALL have port clk, input, 1, clock.
REQ-006 SHALL have port rst, input, 1, reset (synchronous, active-high).
REQ-007 SHALL have port we_i, input, 1, register write strobe.
REQ-008 SHALL have port waddr_i, input, 5, write address.
REQ-009 SHALL have port raddr_i, input, 5, read address.
REQ-010 SHALL have port wdata_i, input, 32, write data.
REQ-011 SHALL have port rdata_o, output, 32, combinational read data.
REQ-012 SHALL have port int_i, input, NUM_HW_INT, level external interrupts.
REQ-013 SHALL have port exc_valid_i, input, 1, exception commit strobe.
REQ-014 SHALL have port exc_code_i, input, 5, ExcCode of committing exception.
REQ-015 SHALL have port exc_pc_i, input, 32, PC of faulting instruction.
REQ-016 SHALL have port exc_bd_i, input, 1, faulting instruction in delay slot.
REQ-017 SHALL have port exc_badvaddr_i, input, 32, faulting address (codes 4/5 only).
REQ-018 SHALL have port eret_i, input, 1, eret commit strobe.
REQ-019 SHALL have ports status_o, cause_o, epc_o, outputs, 32 each, live register values.
REQ-020 SHALL have port int_req_o, input-masked interrupt request, output, 1.
REQ-021 SHALL have port timer_int_o, output, NUM_TIMERS, per-channel sticky timer pending.

Function
REQ-022 Address map: 8 BadVAddr (RO), 9 Count, 11 Compare0, 12 Status, 13 Cause, 14 EPC, 15 PRId (RO), 16 Config (RO 32'h00008000), 24+k Compare k for k=1..NUM_TIMERS-1; unmapped reads return 0.
REQ-023 Count SHALL increment by 1 every COUNT_DIV clocks via prescaler, wrapping 32'hFFFFFFFF->0; write to Count loads wdata_i and clears prescaler, overriding increment that cycle.
REQ-024 timer_int_o[k] SHALL set the cycle after Count==Compare k with Compare k!=0, stay set until Compare k written; write clears it even if matching same cycle.
REQ-025 Cause[15] (IP7) SHALL equal OR of timer_int_o; Cause[10+j] SHALL register int_i[j] each cycle; Cause[9:8] software-writable; Cause[23] (IV) writable; other Cause bits writable only by exception logic.
REQ-026 Status writable bits: [15:8] IM, [1] EXL, [0] IE; [28] CU0 reads 1; others read 0.
REQ-027 int_req_o SHALL be combinational: IE & ~EXL & |(Cause[15:8] & Status[15:8]).
REQ-028 On exc_valid_i with EXL=0: EPC<=exc_pc_i-4 and BD<=1 if exc_bd_i, else EPC<=exc_pc_i and BD<=0; with EXL=1, EPC and BD SHALL be unchanged.
REQ-029 On exc_valid_i: EXL<=1, Cause[6:2]<=exc_code_i regardless of prior EXL; BadVAddr<=exc_badvaddr_i only when exc_code_i is 4 or 5.
REQ-030 On eret_i without exc_valid_i: EXL<=0.
REQ-031 Same-cycle priority: exc_valid_i over eret_i; exception updates over software write to EPC/EXL/ExcCode/BD; software writes to other fields of the same register take effect.
REQ-032 All register updates visible on outputs the cycle after the edge; rdata_o reflects pre-edge values (no write bypass).

Reset
REQ-033 On rst: Count, all Compares, prescaler, BadVAddr, EPC, Cause = 0; Status = 32'h10000000; timer_int_o = 0; reset overrides all same-cycle strobes; int_req_o=0 follows.

Structure
REQ-034 Register address constants, ExcCode values and reset constants SHALL live in the shared defines package.
REQ-035 One sub-module cp0_timer_chan (compare register, match detect, sticky pending) SHALL be instantiated NUM_TIMERS times.

Verification
REQ-036 COUNT_DIV=2, release reset, idle 10 clocks -> Count==5; write Count=32'hFFFFFFFF -> wraps to 0 after 2 clocks.
REQ-037 Compare1=20, Count reaches 20 -> timer_int_o=2'b10, Cause[15]=1; write Compare1=0 -> timer_int_o=0 next cycle.
REQ-038 Status=32'h10008001, timer pending -> int_req_o=1; set EXL -> int_req_o=0.
REQ-039 exc_valid_i code 5, pc 32'h80000104, bd=1, badvaddr 32'h3 -> EPC=32'h80000100, Cause[31]=1, Cause[6:2]=5, BadVAddr=3, EXL=1.
REQ-040 Second exception code 8 while EXL=1 -> EPC unchanged, ExcCode=8; same-cycle eret_i+exc_valid_i -> EXL stays 1.
REQ-041 rst asserted mid-exception (exc_valid_i high) -> all registers at reset values next cycle.
